// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, memory and status signals of the two-master memory bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_we;
  logic                  m0_done;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_we;
  logic                  m1_done;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_req_valid;
  logic                  mem_data_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  grant_id;
  logic                  busy;

  // Arbiter side: takes requests and memory responses, drives everything else.
  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  mem_data_valid, mem_rdata,
    output m0_done, m0_err, m0_rdata,
    output m1_done, m1_err, m1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_req_valid,
    output grant_id, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output mem_data_valid, mem_rdata,
    input  m0_done, m0_err, m0_rdata,
    input  m1_done, m1_err, m1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_req_valid,
    input  grant_id, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin two-master arbiter for a single-port memory bus with timeout watchdog
module mem_bus_arbiter #(
  parameter int MEM_DEPTH  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam int CW         = TIMEOUT_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_EN ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  req_valid_q, req_valid_d;
  logic                  gid_q, gid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  pick;
  logic                  resp_fire;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      req_valid_q <= 1'b0;
      gid_q       <= 1'b0;
      last_q      <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      req_valid_q <= req_valid_d;
      gid_q       <= gid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    req_valid_d = req_valid_q;
    gid_d       = gid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err0_d      = err0_q;
    err1_d      = err1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;

    // On a tie the master that did not win last time gets the bus.
    pick = (bus.m0_req && bus.m1_req) ? ~last_q : ~bus.m0_req;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          addr_d      = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_d     = pick ? bus.m1_wdata : bus.m0_wdata;
          we_d        = pick ? bus.m1_we    : bus.m0_we;
          gid_d       = pick;
          last_d      = pick;
          req_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        // Data arriving on the expiry cycle still counts as a good completion.
        if (bus.mem_data_valid) begin
          resp_fire  = 1'b1;
          resp_rdata = we_q ? '0 : bus.mem_rdata;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end

        if (resp_fire) begin
          req_valid_d = 1'b0;
          state_d     = RESP;
          if (gid_q) begin
            done1_d  = 1'b1;
            err1_d   = resp_err;
            rdata1_d = resp_rdata;
          end else begin
            done0_d  = 1'b1;
            err0_d   = resp_err;
            rdata0_d = resp_rdata;
          end
        end
      end

      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.grant_id      = gid_q;
  assign bus.busy          = busy_q;
  assign bus.m0_done       = done0_q;
  assign bus.m0_err        = err0_q;
  assign bus.m0_rdata      = rdata0_q;
  assign bus.m1_done       = done1_q;
  assign bus.m1_err        = err1_q;
  assign bus.m1_rdata      = rdata1_q;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter that shares the single-port memory bus (addr / wdata / req_valid / we / data_valid) between two masters, e.g. the core's fetch and load/store units.
- Sits between the requesters and Mem_top.
- Round-robin grant, one outstanding transaction at a time, requester fields latched at grant.
- Timeout watchdog returns an error if memory never asserts data_valid.

Parameters:
- MEM_DEPTH, 64: memory words. ADDR_WIDTH = $clog2(MEM_DEPTH).
- DATA_WIDTH, 32: data bus width.
- TIMEOUT, 16: max WAIT cycles before error. 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request (level)
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wdata  in  DATA_WIDTH  master 0 write data
- m0_we  in  1  master 0 write enable (1 = write)
- m0_done  out  1  one-cycle completion pulse to master 0
- m0_err  out  1  timeout flag, valid with m0_done
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_done, held until the next m0_done
- m1_req, m1_addr, m1_wdata, m1_we, m1_done, m1_err, m1_rdata: identical for master 1
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write enable
- mem_req_valid  out  1  memory request
- mem_data_valid  in  1  memory completion strobe
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_data_valid
- grant_id  out  1  owner of the current or last transaction
- busy  out  1  high in WAIT and RESP

Behaviour:
- Reset (async, immediate): state = IDLE; all outputs = 0; last_grant = 1, so master 0 wins the first tie.
- Reset asserted mid-transaction drops mem_req_valid in the same cycle; no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that master.
- IDLE, both requesting: grant the master != last_grant.
- At grant:
  - latch addr/wdata/we into mem_addr/mem_wdata/mem_we;
  - set grant_id and last_grant;
  - set mem_req_valid = 1; clear the timeout counter;
  - go to WAIT.
- Latency: request sampled at edge N -> mem_req_valid high from cycle N+1.
- WAIT: mem_req_valid and the latched fields are held stable; the counter increments each cycle.
  - mem_data_valid = 1: capture mem_rdata into the granted master's rdata (writes capture 0); err = 0; mem_req_valid -> 0; go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: rdata = 0; err = 1; mem_req_valid -> 0; go to RESP.
  - mem_data_valid in the same cycle as expiry: data wins, err = 0.
- RESP: granted master's done = 1 for exactly one cycle; the other master's done/err/rdata are unchanged; go to IDLE.
  - err clears on that master's next done.
- IDLE sampling: a requester still high in IDLE after its done is treated as a new request. Back-to-back transactions from one master therefore take 3 cycles minimum with a 1-cycle memory.
- Requests arriving during WAIT/RESP are not latched; the master must hold req until its done.
- mem_data_valid in IDLE or RESP: ignored, no state change.
- Fields change only in IDLE at grant. Requester changes to addr/wdata/we during WAIT do not reach the memory.
- Counter width: $clog2(TIMEOUT+1); saturates and never wraps.

Test Plan:
- Single read: m0_req=1, m0_addr=5, m0_we=0; memory returns 0xDEADBEEF with data_valid 2 cycles after mem_req_valid -> mem_addr=5 and mem_req_valid high from cycle N+1; m0_done pulses 1 cycle with m0_rdata=0xDEADBEEF, m0_err=0; m1 outputs stay 0.
- Contention: m0_req and m1_req high together from reset, held -> grants m0, m1, m0, m1 alternating; grant_id toggles; every done is exactly one cycle.
- Write: m1_req=1, m1_we=1, m1_addr=63, m1_wdata=0x12345678 -> mem_we=1, mem_addr=63, mem_wdata=0x12345678 held through WAIT; m1_done with m1_rdata=0.
- Timeout: TIMEOUT=16, memory never responds -> mem_req_valid drops after 16 WAIT cycles; m0_done=1, m0_err=1, m0_rdata=0. Next request succeeds and clears m0_err.
- Data at expiry: mem_data_valid on the 16th WAIT cycle with 0xA5A5A5A5 -> err=0, rdata=0xA5A5A5A5.
- Reset mid-WAIT: assert reset while mem_req_valid=1 -> mem_req_valid, busy and done all 0 in the same cycle. After release, a tie is granted to m0.
